serial_nibble_add_ctrl: RTL and testbench

- Sequencer that adds two NIBBLES*4-bit operands by reusing one 4-bit adder slice over successive cycles, least-significant nibble first.
- A carry register chains each nibble to the next.
- Sits between a requester (valid/ready command side) and a consumer (valid/ready result side). It is the time-multiplexed replacement for a wide ripple adder in area-constrained arithmetic paths.

---
 rtl/serial_nibble_add_ctrl_pkg.sv | 15 +
 rtl/serial_nibble_add_ctrl_nibble_adder_cin.sv | 25 ++
 rtl/serial_nibble_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_nibble_add_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_add_ctrl_pkg.sv
// Package serial_add_pkg: shared constants and FSM state type for the
// serial nibble adder sequencer.
//   NIBBLE_W : width of the reused adder slice
//   state_t  : IDLE / RUN / DONE controller states (2'b11 is illegal)
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_nibble_add_ctrl_nibble_adder_cin.sv
// nibble_adder_cin: combinational 4-bit adder slice with carry-in.
// Ports:
//   x, y : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out
module nibble_adder_cin
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] full;

    always_comb begin
        full = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};
        s    = full[NIBBLE_W-1:0];
        co   = full[NIBBLE_W];
    end

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// serial_nibble_add_ctrl: adds two NIBBLES*4-bit operands by passing them
// through one 4-bit adder slice, least-significant nibble first, with a
// carry register chaining nibble to nibble.
// Optional build macro: OVERFLOW_FLAG_EN adds the signed-overflow port ovf.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : command handshake (ready only in IDLE)
//   a, b, cin                : operands, sampled on the command handshake
//   res_valid/res_ready      : result handshake (valid only in DONE)
//   sum, cout                : registered W-bit sum and carry out
//   busy                     : high in RUN or DONE
//   ovf                      : two's-complement overflow (OVERFLOW_FLAG_EN)
module serial_nibble_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [NIBBLES*4-1:0]    a,
    input  logic [NIBBLES*4-1:0]    b,
    input  logic                    cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NIBBLES*4-1:0]    sum,
    output logic                    cout,
    output logic                    busy
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                    ovf
`endif
);

    localparam int unsigned W  = NIBBLES * NIBBLE_W;
    localparam int unsigned CW = $clog2((NIBBLES > 2) ? NIBBLES : 2);

    state_t state_q, state_d;

    logic [W-1:0]        a_q, b_q, sum_q;
    logic                carry_q, cout_q;
    logic [CW-1:0]       cnt_q;
    logic                load_en, run_en, last;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    nibble_adder_cin u_slice (
        .x  (a_q[NIBBLE_W-1:0]),
        .y  (b_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last = (cnt_q == CW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        load_en     = 1'b0;
        run_en      = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load_en = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                run_en = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Each RUN edge retires one nibble: the new slice result enters the top
    // of sum while older nibbles move down, so after NIBBLES edges nibble 0
    // has reached the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (load_en) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (run_en) begin
            a_q     <= a_q >> NIBBLE_W;
            b_q     <= b_q >> NIBBLE_W;
            sum_q   <= (sum_q >> NIBBLE_W) | (W'(slice_s) << (W - NIBBLE_W));
            carry_q <= slice_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= slice_co;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    // Carry into the sign bit differs from carry out exactly when both
    // top-nibble sign bits agree and the result sign bit does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (run_en && last) begin
            ovf_q <= (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                     (slice_s[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
module tb_serial_nibble_add_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = NIBBLES * 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    serial_nibble_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           first;
    } exp_t;

    exp_t q[$];

    bit hold_ready  = 1'b0;
    bit force_ready = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input int first);
        exp_t            e;
        longint unsigned u;
        longint          s, lim;
        u       = longint'(ia) + longint'(ib) + longint'(ic);
        e.sum   = u[W-1:0];
        e.cout  = u[W];
        lim     = longint'(1) <<< (W - 1);
        s       = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
        e.ovf   = (s > lim - 1) || (s < -lim);
        e.first = first;
        return e;
    endfunction

    // Result consumer: random backpressure unless a directed test pins it.
    always begin
        @(posedge clk);
        #1;
        res_ready = hold_ready ? force_ready : 1'($urandom_range(0, 1));
    end

    // Monitor / scoreboard.
    logic         pv = 1'b0, pr = 1'b0, pc = 1'b0;
    logic [W-1:0] ps = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (res_valid && !pv) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    chk("latency", cyc, q[0].first);
                    chk("busy_in_done", busy, 1);
                end
            end
            if (res_valid && pv && !pr) begin
                chk("hold_sum", sum, ps);
                chk("hold_cout", cout, pc);
                chk("hold_start_ready", start_ready, 0);
            end
            if (res_valid && res_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
`ifdef OVERFLOW_FLAG_EN
                chk("ovf", ovf, e.ovf);
`endif
            end
            pv = res_valid;
            pr = res_ready;
            ps = sum;
            pc = cout;
        end
    end

    // Starts and ends at a negedge; returns the negedge after the handshake.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input bit zero_after, input bit push);
        int n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("start_timeout", 1, 0);
            start_valid = 1'b0;
            return;
        end
        if (push) q.push_back(model(ia, ib, ic, cyc + 1 + NIBBLES));
        @(negedge clk);
        start_valid = 1'b0;
        a   = zero_after ? '0 : W'($urandom);
        b   = zero_after ? '0 : W'($urandom);
        cin = zero_after ? 1'b0 : 1'($urandom);
        chk("busy_in_run", busy, 1);
        chk("ready_low_in_run", start_ready, 0);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = res_valid;
        if (!ok) chk("res_valid_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;

        // Reset state
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef OVERFLOW_FLAG_EN
        chk("rst_ovf", ovf, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        issue(16'h00D7, 16'h0042, 1'b0, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(16'h9F9F, 16'hF9F9, 1'b1, 1'b1, 1'b1);
`ifdef OVERFLOW_FLAG_EN
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
`endif

        // Backpressure in DONE with a command pulsed meanwhile
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        hold_ready = 1'b1; force_ready = 1'b0;
        @(negedge clk);
        issue(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b1);
        wait_valid(ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                chk("bp_res_valid", res_valid, 1);
                chk("bp_start_ready", start_ready, 0);
                start_valid = (i == 1);
                @(negedge clk);
            end
            start_valid = 1'b0;
            force_ready = 1'b1;
            n = 0;
            while (res_valid && n < 10) begin @(negedge clk); n++; end
            chk("release_start_ready", start_ready, 1);
            for (int i = 0; i < 3; i++) begin
                chk("ignored_cmd_no_result", res_valid, 0);
                chk("ignored_cmd_idle", busy, 0);
                @(negedge clk);
            end
        end
        hold_ready = 1'b0;

        // Reset in the middle of RUN
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_start_ready", start_ready, 1);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) begin ra = '1; rb = W'(i / 8); end
            issue(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain
        n = 0;
        while ((q.size() != 0 || res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
